// File: rtl/mult_seq_hs.sv
// Sequential shift-add multiplier, N x N -> 2N, retiring R multiplier bits per cycle, valid/ready on both sides.
// Optional macro MULT_EARLY_TERM_EN: finish as soon as the remaining multiplier bits are all zero.
module mult_seq_hs #(
    parameter int N = 256,
    parameter int R = 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start_valid,
    output logic           start_ready,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    output logic [2*N-1:0] prod,
    output logic           done_valid,
    input  logic           done_ready,
    output logic           busy,
    output logic [1:0]     state
);

    localparam int STEPS = N / R;
    localparam int CW    = $clog2(STEPS) + 1;
    localparam int RL    = $clog2(R);
    localparam int SW    = CW + 2;

    generate
        if (N < 2 || !(R == 1 || R == 2 || R == 4) || (N % R) != 0) begin : g_bad_param
            $error("mult_seq_hs: N must be >= 2, R in {1,2,4} and N %% R == 0");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MULT = 2'd1,
        S_DONE = 2'd2,
        S_ILL  = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [2*N-1:0]  acc_q, acc_d;
    logic [N-1:0]    mreg_q, mreg_d;
    logic [N-1:0]    breg_q, breg_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2*N-1:0]  prod_q, prod_d;
    logic            done_valid_q, done_valid_d;

    logic [2*N-1:0]  b_ext;
    logic [2*N-1:0]  pp_term [R];
    logic [2*N-1:0]  pp_sum;
    logic [SW-1:0]   shamt;
    logic [2*N-1:0]  acc_nxt;
    logic [N-1:0]    mreg_shift;
    logic            last_step;

    assign b_ext = {{N{1'b0}}, breg_q};

    // One gated, pre-shifted copy of the multiplicand per retired multiplier bit.
    genvar gi;
    generate
        for (gi = 0; gi < R; gi++) begin : g_pp
            assign pp_term[gi] = mreg_q[gi] ? (b_ext << gi) : '0;
        end
    endgenerate

    always_comb begin
        pp_sum = '0;
        for (int i = 0; i < R; i++) begin
            pp_sum = pp_sum + pp_term[i];
        end
    end

    // R is a power of two, so cnt*R is a plain left shift.
    assign shamt      = SW'(cnt_q) << RL;
    assign acc_nxt    = acc_q + (pp_sum << shamt);
    assign mreg_shift = mreg_q >> R;

`ifdef MULT_EARLY_TERM_EN
    assign last_step = (cnt_q == CW'(STEPS - 1)) || (mreg_shift == '0);
`else
    assign last_step = (cnt_q == CW'(STEPS - 1));
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            acc_q        <= '0;
            mreg_q       <= '0;
            breg_q       <= '0;
            cnt_q        <= '0;
            prod_q       <= '0;
            done_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            acc_q        <= acc_d;
            mreg_q       <= mreg_d;
            breg_q       <= breg_d;
            cnt_q        <= cnt_d;
            prod_q       <= prod_d;
            done_valid_q <= done_valid_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        acc_d        = acc_q;
        mreg_d       = mreg_q;
        breg_d       = breg_q;
        cnt_d        = cnt_q;
        prod_d       = prod_q;
        done_valid_d = done_valid_q;
        case (state_q)
            S_IDLE: begin
                if (start_valid) begin
                    mreg_d  = a;
                    breg_d  = b;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = S_MULT;
                end
            end
            S_MULT: begin
                acc_d  = acc_nxt;
                mreg_d = mreg_shift;
                cnt_d  = cnt_q + CW'(1);
                if (last_step) begin
                    prod_d       = acc_nxt;
                    done_valid_d = 1'b1;
                    state_d      = S_DONE;
                end
            end
            S_DONE: begin
                if (done_ready) begin
                    done_valid_d = 1'b0;
                    state_d      = S_IDLE;
                end
            end
            default: begin
                done_valid_d = 1'b0;
                state_d      = S_IDLE;
            end
        endcase
    end

    // The unreachable encoding presents reset-value outputs until it falls back to IDLE.
    assign start_ready = (state_q == S_IDLE) || (state_q == S_ILL);
    assign busy        = (state_q == S_MULT) || (state_q == S_DONE);
    assign done_valid  = done_valid_q && (state_q == S_DONE);
    assign prod        = (state_q == S_ILL) ? '0 : prod_q;
    assign state       = state_q;

endmodule

// File: tb/tb_mult_seq_hs.sv
// Directed-vector and random checks of mult_seq_hs in three configurations (8/1, 8/2, 256/4).
module tb_mult_seq_hs;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    logic [255:0] a_bus, b_bus;
    logic [2:0]   sv, dr;
    logic         sr0, sr1, sr2, dv0, dv1, dv2, bz0, bz1, bz2;
    logic [1:0]   st0, st1, st2;
    logic [15:0]  p0, p1;
    logic [511:0] p2;

    int n_checks = 0;
    int n_fail   = 0;

    mult_seq_hs #(.N(8), .R(1)) u0 (
        .clk(clk), .rst(rst), .start_valid(sv[0]), .start_ready(sr0),
        .a(a_bus[7:0]), .b(b_bus[7:0]), .prod(p0), .done_valid(dv0),
        .done_ready(dr[0]), .busy(bz0), .state(st0));

    mult_seq_hs #(.N(8), .R(2)) u1 (
        .clk(clk), .rst(rst), .start_valid(sv[1]), .start_ready(sr1),
        .a(a_bus[7:0]), .b(b_bus[7:0]), .prod(p1), .done_valid(dv1),
        .done_ready(dr[1]), .busy(bz1), .state(st1));

    mult_seq_hs #(.N(256), .R(4)) u2 (
        .clk(clk), .rst(rst), .start_valid(sv[2]), .start_ready(sr2),
        .a(a_bus), .b(b_bus), .prod(p2), .done_valid(dv2),
        .done_ready(dr[2]), .busy(bz2), .state(st2));

    typedef struct {
        int           sel;
        logic [255:0] a;
        logic [255:0] b;
        logic [511:0] p;
    } vec_t;

    vec_t vecs[13];

    function automatic logic [511:0] prod_of(input int sel);
        case (sel)
            0:       return {496'd0, p0};
            1:       return {496'd0, p1};
            default: return p2;
        endcase
    endfunction

    function automatic logic dv_of(input int sel);
        case (sel)
            0:       return dv0;
            1:       return dv1;
            default: return dv2;
        endcase
    endfunction

    function automatic logic sr_of(input int sel);
        case (sel)
            0:       return sr0;
            1:       return sr1;
            default: return sr2;
        endcase
    endfunction

    function automatic int n_of(input int sel);
        return (sel == 2) ? 256 : 8;
    endfunction

    function automatic int r_of(input int sel);
        case (sel)
            0:       return 1;
            1:       return 2;
            default: return 4;
        endcase
    endfunction

    function automatic int exp_lat(input int sel, input logic [255:0] a);
        int n, r, bl, l;
        n = n_of(sel);
        r = r_of(sel);
`ifdef MULT_EARLY_TERM_EN
        bl = 0;
        for (int i = 0; i < n; i++) begin
            if (a[i]) bl = i + 1;
        end
        l = (bl + r - 1) / r;
        if (l < 1) l = 1;
`else
        bl = 0;
        l  = n / r + bl;
`endif
        return l;
    endfunction

    function automatic logic [255:0] rnd256();
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", nm, act, exp);
        end
    endtask

    // Issue one operation, wait for the result with done_ready high, check product and latency.
    task automatic run_op(input int sel, input logic [255:0] a, input logic [255:0] b,
                          input logic [511:0] exp, input string nm);
        int waitc, lat;
        a_bus   = a;
        b_bus   = b;
        dr[sel] = 1'b1;
        sv[sel] = 1'b1;
        waitc   = 0;
        while (!sr_of(sel) && waitc < 1000) begin
            @(negedge clk);
            waitc++;
        end
        if (!sr_of(sel)) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s start_ready timeout: got 0, required 1", nm);
            sv[sel] = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        sv[sel] = 1'b0;
        a_bus   = ~a;
        b_bus   = ~b;
        lat     = 0;
        while (!dv_of(sel) && lat < 1000) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk($sformatf("%s done_valid", nm), {511'd0, dv_of(sel)}, 512'd1);
        chk($sformatf("%s prod", nm), prod_of(sel), exp);
        chk($sformatf("%s latency", nm), 512'(lat), 512'(exp_lat(sel, a)));
        $display("op %s cfg=%0d a=%0h b=%0h prod=%0h lat=%0d", nm, sel, a, b, prod_of(sel), lat);
        @(negedge clk);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [255:0] ra, rb;
        logic [511:0] rp, held;
        int           waitc;
        bit           seen;

        vecs[0]  = '{0, 256'hFF, 256'hFF, 512'hFE01};
        vecs[1]  = '{0, 256'h00, 256'hAB, 512'h0};
        vecs[2]  = '{0, 256'h80, 256'h80, 512'h4000};
        vecs[3]  = '{0, 256'h01, 256'h05, 512'h0005};
        vecs[4]  = '{0, 256'h12, 256'h34, 512'h03A8};
        vecs[5]  = '{1, 256'hC3, 256'h0A, 512'h079E};
        vecs[6]  = '{1, 256'hFF, 256'hFF, 512'hFE01};
        vecs[7]  = '{1, 256'h01, 256'hFF, 512'h00FF};
        vecs[8]  = '{1, 256'h40, 256'h03, 512'h00C0};
        vecs[9]  = '{2, {256{1'b1}}, {256{1'b1}}, {{255{1'b1}}, {256{1'b0}}, 1'b1}};
        vecs[10] = '{2, 256'd1, {256{1'b1}}, {256'd0, {256{1'b1}}}};
        vecs[11] = '{2, {1'b1, 255'd0}, 256'd2, {255'd0, 1'b1, 256'd0}};
        vecs[12] = '{2, 256'd0, {256{1'b1}}, 512'd0};

        rst   = 1'b0;
        sv    = '0;
        dr    = '0;
        a_bus = '0;
        b_bus = '0;
        repeat (3) @(negedge clk);
        chk("reset state0", 512'(st0), 512'd0);
        chk("reset prod0", {496'd0, p0}, 512'd0);
        chk("reset done_valid0", 512'(dv0), 512'd0);
        chk("reset busy0", 512'(bz0), 512'd0);
        chk("reset start_ready0", 512'(sr0), 512'd1);
        chk("reset start_ready1", 512'(sr1), 512'd1);
        chk("reset start_ready2", 512'(sr2), 512'd1);
        chk("reset prod2", p2, 512'd0);
        rst = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 13; i++) begin
            run_op(vecs[i].sel, vecs[i].a, vecs[i].b, vecs[i].p, $sformatf("vec%0d", i));
        end

        // Back-pressure: result held for 10 cycles while a new start is offered.
        a_bus = 256'h9C;
        b_bus = 256'h3B;
        dr[0] = 1'b0;
        sv[0] = 1'b1;
        @(posedge clk);
        #1;
        sv[0] = 1'b0;
        waitc = 0;
        while (!dv0 && waitc < 100) begin
            @(posedge clk);
            #1;
            waitc++;
        end
        chk("bp done_valid", 512'(dv0), 512'd1);
        held = {496'd0, p0};
        chk("bp prod", held, 512'h23F4);
        sv[0] = 1'b1;
        a_bus = 256'h11;
        b_bus = 256'h11;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1;
            chk($sformatf("bp hold%0d prod", c), {496'd0, p0}, 512'h23F4);
            chk($sformatf("bp hold%0d dv", c), 512'(dv0), 512'd1);
            chk($sformatf("bp hold%0d state", c), 512'(st0), 512'd2);
        end
        $display("op backpressure cfg=0 a=9c b=3b prod=%0h held 10 cycles", p0);
        @(negedge clk);
        sv[0] = 1'b0;
        dr[0] = 1'b1;
        @(posedge clk);
        #1;
        chk("bp release state", 512'(st0), 512'd0);
        chk("bp release start_ready", 512'(sr0), 512'd1);
        chk("bp release dv", 512'(dv0), 512'd0);
        chk("bp release prod kept", {496'd0, p0}, 512'h23F4);
        @(negedge clk);

        // Asynchronous reset mid-cycle while a result is waiting.
        a_bus = 256'h12;
        b_bus = 256'h34;
        dr[0] = 1'b0;
        sv[0] = 1'b1;
        @(posedge clk);
        #1;
        sv[0] = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        chk("arst pre dv", 512'(dv0), 512'd1);
        chk("arst pre prod", {496'd0, p0}, 512'h03A8);
        #3;
        rst = 1'b0;
        #1;
        chk("arst state", 512'(st0), 512'd0);
        chk("arst prod", {496'd0, p0}, 512'd0);
        chk("arst dv", 512'(dv0), 512'd0);
        chk("arst busy", 512'(bz0), 512'd0);
        chk("arst start_ready", 512'(sr0), 512'd1);
        $display("op async_reset cfg=0 prod=%0h state=%0d", p0, st0);
        @(negedge clk);
        rst   = 1'b1;
        dr[0] = 1'b1;
        @(negedge clk);

        // Reset pulse at cnt=3 aborts the operation.
        a_bus = 256'h55;
        b_bus = 256'h33;
        sv[0] = 1'b1;
        @(posedge clk);
        #1;
        sv[0] = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst  = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk);
            #1;
            if (dv0) seen = 1'b1;
        end
        chk("abort no done_valid", 512'(seen), 512'd0);
        chk("abort state idle", 512'(st0), 512'd0);
        $display("op abort cfg=0 a=55 b=33 done_seen=%0d", seen);
        @(negedge clk);
        run_op(0, 256'h02, 256'h07, 512'h000E, "after_abort");

        for (int i = 0; i < 1000; i++) begin
            ra = 256'($urandom_range(0, 255));
            rb = 256'($urandom_range(0, 255));
            rp = {256'd0, ra} * {256'd0, rb};
            run_op(0, ra, rb, rp, $sformatf("rnd8r1_%0d", i));
        end
        for (int i = 0; i < 1000; i++) begin
            ra = 256'($urandom_range(0, 255));
            rb = 256'($urandom_range(0, 255));
            rp = {256'd0, ra} * {256'd0, rb};
            run_op(1, ra, rb, rp, $sformatf("rnd8r2_%0d", i));
        end
        for (int i = 0; i < 200; i++) begin
            ra = rnd256() >> $urandom_range(0, 255);
            rb = rnd256();
            rp = {256'd0, ra} * {256'd0, rb};
            run_op(2, ra, rb, rp, $sformatf("rnd256r4_%0d", i));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
